// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM states, frame size and register map for the SPI register bank
package spi_reg_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;
   localparam int FRAME_BITS = 16;
   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;
   localparam logic [6:0] MAX_ADDR       = 7'h04;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchroniser for an async pin with rise/fall pulses
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   // shift the pin through the synchroniser and keep one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         prev <= level;
      end
   end
   assign level = sync[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-slave bank of five PWM control registers; SPI_READBACK_EN adds read frames on cipo
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DUTY_RESET  = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ncs,
   input  logic       copi,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle
);
   logic       sclk_s, sclk_rise, sclk_fall;
   logic       ncs_s, ncs_rise, ncs_fall;
   logic       copi_s, copi_rise, copi_fall;
   logic       unused_sync;
   state_t     state;
   logic [4:0] cnt;
   logic [15:0] sh;
   logic       start, sample, wr_en;
   logic [6:0] addr;
   logic [7:0] data;
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .rst(rst), .d(sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs (
      .clk(clk), .rst(rst), .d(ncs), .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_copi (
      .clk(clk), .rst(rst), .d(copi), .level(copi_s), .rise(copi_rise), .fall(copi_fall)
   );
   assign unused_sync = ^{sclk_s, sclk_fall, ncs_s, copi_rise, copi_fall};
   assign start  = (state == IDLE) && ncs_fall;
   assign sample = (state == SHIFT) && !ncs_rise && sclk_rise;
   assign addr   = sh[14:8];
   assign data   = sh[7:0];
   assign wr_en  = (state == COMMIT) && (cnt == 5'(FRAME_BITS)) && sh[15] && (addr <= MAX_ADDR);
   // frame FSM: open on ncs fall, shift copi on sclk rise, close on ncs rise (ncs wins ties)
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sh    <= '0;
      end else begin
         state <= start ? SHIFT : (state == SHIFT && ncs_rise) ? COMMIT : (state == COMMIT) ? IDLE : state;
         if (start) begin
            cnt <= '0;
            sh  <= '0;
         end else if (sample) begin
            sh  <= {sh[14:0], copi_s};
            cnt <= (cnt == 5'(FRAME_BITS + 1)) ? cnt : cnt + 5'd1;
         end
      end
   end
   // register file: only a complete, in-range write frame updates a register
   always_ff @(posedge clk) begin
      if (rst) begin
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= DUTY_RESET;
      end else if (wr_en) begin
         en_reg_out_7_0  <= (addr == ADDR_EN_OUT_LO) ? data : en_reg_out_7_0;
         en_reg_out_15_8 <= (addr == ADDR_EN_OUT_HI) ? data : en_reg_out_15_8;
         en_reg_pwm_7_0  <= (addr == ADDR_EN_PWM_LO) ? data : en_reg_pwm_7_0;
         en_reg_pwm_15_8 <= (addr == ADDR_EN_PWM_HI) ? data : en_reg_pwm_15_8;
         pwm_duty_cycle  <= (addr == ADDR_DUTY)      ? data : pwm_duty_cycle;
      end
   end
`ifdef SPI_READBACK_EN
   logic [6:0] rd_addr;
   logic [7:0] rd_data, tx;
   logic       rd, cipo_q;
   assign rd_addr = {sh[5:0], copi_s};
   assign rd_data = (rd_addr == ADDR_EN_OUT_LO) ? en_reg_out_7_0 :
                    (rd_addr == ADDR_EN_OUT_HI) ? en_reg_out_15_8 :
                    (rd_addr == ADDR_EN_PWM_LO) ? en_reg_pwm_7_0 :
                    (rd_addr == ADDR_EN_PWM_HI) ? en_reg_pwm_15_8 :
                    (rd_addr == ADDR_DUTY)      ? pwm_duty_cycle : 8'h00;
   // read shifter: load on the 8th sampled bit, shift on each later sclk fall, drive cipo one cycle behind
   always_ff @(posedge clk) begin
      if (rst) begin
         tx     <= 8'h00;
         rd     <= 1'b0;
         cipo_q <= 1'b0;
      end else begin
         if (start) begin
            tx <= 8'h00;
            rd <= 1'b0;
         end else if (sample && cnt == 5'd7) begin
            tx <= sh[6] ? 8'h00 : rd_data;
            rd <= ~sh[6];
         end else if (rd && sclk_fall) begin
            tx <= {tx[6:0], 1'b0};
         end
         cipo_q <= (rd && !ncs_s && state == SHIFT) ? tx[7] : 1'b0;
      end
   end
   assign cipo = cipo_q;
`else
   assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: table-driven scoreboard bench for the SPI register bank
module tb_spi_reg_bank;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       ncs = 1'b1;
   logic       copi = 1'b0;
   logic       cipo;
   logic [7:0] r0, r1, r2, r3, r4;
   int         n_cmp = 0;
   int         n_fail = 0;
   typedef struct {
      logic [15:0] frame;
      int          nbits;
      logic [39:0] exp;
   } vec_t;
   vec_t        tbl[8];
   logic [39:0] sb[$];
   logic [39:0] e;
   logic [7:0]  rx;

   always #5 clk = ~clk;

   spi_reg_bank dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
      .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
      .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4)
   );

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string tag, input logic [39:0] x);
      check8({tag, " en_out_lo"}, r0, x[7:0]);
      check8({tag, " en_out_hi"}, r1, x[15:8]);
      check8({tag, " en_pwm_lo"}, r2, x[23:16]);
      check8({tag, " en_pwm_hi"}, r3, x[31:24]);
      check8({tag, " duty"},      r4, x[39:32]);
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_frame(input logic [15:0] f, input int nbits, input int rst_at, output logic [7:0] rxd);
      rxd = 8'h00;
      ncs = 1'b0;
      clk_wait(6);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            clk_wait(2);
            rst = 1'b0;
         end
         copi = (i < 16) ? f[15-i] : 1'b0;
         clk_wait(5);
         sclk = 1'b1;
         clk_wait(5);
         if (i >= 7 && i < 15) rxd = {rxd[6:0], cipo};
         sclk = 1'b0;
      end
      clk_wait(5);
      ncs = 1'b1;
   endtask

   initial begin
      tbl[0] = '{16'h80F0, 16, 40'h80_00_00_00_F0};
      tbl[1] = '{16'h810F, 16, 40'h80_00_00_0F_F0};
      tbl[2] = '{16'h82AA, 16, 40'h80_00_AA_0F_F0};
      tbl[3] = '{16'h8355, 16, 40'h80_55_AA_0F_F0};
      tbl[4] = '{16'h8555, 16, 40'h80_55_AA_0F_F0};
      tbl[5] = '{16'h8311, 12, 40'h80_55_AA_0F_F0};
      tbl[6] = '{16'h8311, 17, 40'h80_55_AA_0F_F0};
      tbl[7] = '{16'h0400, 16, 40'h80_55_AA_0F_F0};
      clk_wait(2);
      rst = 1'b0;
      check_regs("reset", 40'h0);
      check8("reset cipo", {7'b0, cipo}, 8'h00);
      clk_wait(4);
      spi_frame(16'h8480, 16, -1, rx);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 check8("duty before latency", r4, 8'h00);
      @(posedge clk);
      #1 check8("duty at latency", r4, 8'h80);
      clk_wait(8);
      check_regs("duty write", 40'h80_00_00_00_00);
      for (int i = 0; i < 8; i++) begin
         sb.push_back(tbl[i].exp);
         spi_frame(tbl[i].frame, tbl[i].nbits, -1, rx);
         clk_wait(8);
         e = sb.pop_front();
         check_regs($sformatf("vec%0d", i), e);
         check8($sformatf("vec%0d cipo idle", i), {7'b0, cipo}, 8'h00);
`ifdef SPI_READBACK_EN
         if (!tbl[i].frame[15] && tbl[i].nbits == 16) check8($sformatf("vec%0d readback", i), rx, 8'h80);
`endif
      end
      sb.push_back(40'h0);
      spi_frame(16'h823C, 16, 9, rx);
      clk_wait(8);
      e = sb.pop_front();
      check_regs("reset mid-frame", e);
      sb.push_back(40'h00_00_3C_00_00);
      spi_frame(16'h823C, 16, -1, rx);
      clk_wait(8);
      e = sb.pop_front();
      check_regs("after reset write", e);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
